// File: rtl/apb_slave_sync.sv
// APB completer with a small word-addressed register bank: word 0 returns STATUS (read-only),
// words 1..NREGS-1 are read/write control words. Fixed wait-state insertion and PSLVERR on bad access.
module apb_slave_sync #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 32,
  parameter int NREGS       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AWIDTH-1:0]             PADDR,
  input  logic [DWIDTH-1:0]             PWDATA,
  input  logic [DWIDTH-1:0]             STATUS,
  output logic                          PREADY,
  output logic [DWIDTH-1:0]             PRDATA,
  output logic                          PSLVERR,
  output logic [(NREGS-1)*DWIDTH-1:0]   CTRL
);

  localparam int IW       = $clog2(NREGS);
  localparam int ADDR_MSB = IW + 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DWIDTH-1:0] prdata_q, prdata_d;
  logic [DWIDTH-1:0] regs_q [1:NREGS-1];
  logic [DWIDTH-1:0] regs_d [1:NREGS-1];

  logic [IW-1:0]     idx;
  logic [31:0]       idx_ext;
  logic              oor;
  logic [DWIDTH-1:0] rd_word;
  logic              commit;

  // Address decode and read mux for the setup phase.
  always_comb begin
    idx     = PADDR[ADDR_MSB:2];
    idx_ext = 32'(idx);
    oor     = (|(PADDR >> (ADDR_MSB + 1))) || (idx_ext >= NREGS);
    rd_word = '0;
    if (idx == '0) begin
      rd_word = STATUS;
    end else begin
      for (int k = 1; k < NREGS; k++) begin
        if (idx == IW'(k)) rd_word = regs_q[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_STATES);
          err_d    = oor || (PWRITE && (idx == '0));
          wr_d     = PWRITE;
          idx_d    = idx;
          prdata_d = (PWRITE || oor) ? '0 : rd_word;
        end
      end
      ACCESS: begin
        // Losing PSEL mid-access abandons the transfer without a commit.
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          if (PENABLE) cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          commit  = wr_q && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 1; k < NREGS; k++) begin
      regs_d[k] = regs_q[k];
      if (commit && (idx_q == IW'(k))) regs_d[k] = PWDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
      for (int k = 1; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
      for (int k = 1; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = prdata_q;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_ctrl
      assign CTRL[gi*DWIDTH-1 -: DWIDTH] = regs_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_apb_slave_sync.sv
// Bench for apb_slave_sync: three instances (0, 3 and 2 wait states) driven by directed and
// random APB transfers, checked against an array model of the register bank.
module tb_apb_slave_sync;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] status;
  logic        pready [3];
  logic        pslverr [3];
  logic [31:0] prdata [3];
  logic [223:0] ctrl [3];

  int ws_of [3] = '{0, 3, 2};
  logic [31:0] mdl [3][8];
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_slave_sync #(.DWIDTH(32), .AWIDTH(32), .NREGS(8), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .STATUS(status), .PREADY(pready[0]),
    .PRDATA(prdata[0]), .PSLVERR(pslverr[0]), .CTRL(ctrl[0]));
  apb_slave_sync #(.DWIDTH(32), .AWIDTH(32), .NREGS(8), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .STATUS(status), .PREADY(pready[1]),
    .PRDATA(prdata[1]), .PSLVERR(pslverr[1]), .CTRL(ctrl[1]));
  apb_slave_sync #(.DWIDTH(32), .AWIDTH(32), .NREGS(8), .WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .STATUS(status), .PREADY(pready[2]),
    .PRDATA(prdata[2]), .PSLVERR(pslverr[2]), .CTRL(ctrl[2]));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [223:0] mdl_ctrl(input int i);
    logic [223:0] r;
    r = '0;
    for (int k = 1; k < 8; k++) r[k*32-1 -: 32] = mdl[i][k];
    return r;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) mdl[i][k] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_pready"}, pready[i], 0);
      check({tag, "_pslverr"}, pslverr[i], 0);
      check({tag, "_prdata"}, prdata[i], 0);
      check({tag, "_ctrl"}, ctrl[i], 0);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completion edge.
  task automatic xfer(input int i, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] st);
    logic [2:0]  idx;
    bit          oor, err;
    logic [31:0] exp_rd;
    int          waits;
    idx    = addr[4:2];
    oor    = (addr[31:5] != 27'd0);
    err    = oor || (wr && idx == 3'd0);
    exp_rd = (wr || oor) ? 32'd0 : ((idx == 3'd0) ? st : mdl[i][idx]);
    status = st;
    psel[i] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge PCLK); @(negedge PCLK);
    status  = $urandom;
    penable = 1'b1;
    waits   = 0;
    while (!pready[i] && waits <= 20) begin
      waits++;
      @(posedge PCLK); @(negedge PCLK);
    end
    check("wait_states", waits, ws_of[i]);
    check("prdata", prdata[i], exp_rd);
    check("pslverr", pslverr[i], err);
    check("ctrl_pre_commit", ctrl[i], mdl_ctrl(i));
    $display("xfer u%0d wr=%0d addr=%h wdata=%h rdata=%h err=%0d waits=%0d",
             i, wr, addr, wdata, prdata[i], pslverr[i], waits);
    @(posedge PCLK);
    if (wr && !err) mdl[i][idx] = wdata;
    @(negedge PCLK);
    psel[i] = 1'b0; penable = 1'b0;
    check("ctrl_post_commit", ctrl[i], mdl_ctrl(i));
    check("pready_idle", pready[i], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    PRESET = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; status = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    mdl_clear();

    // Reset with bus activity
    @(posedge PCLK);
    repeat (2) begin
      @(negedge PCLK);
      check_all_zero("reset");
      for (int i = 0; i < 3; i++) psel[i] = 1'($urandom);
      penable = 1'($urandom);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    check_all_zero("reset_end");
    PRESET = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    @(negedge PCLK);

    // Basic write/read, zero wait states
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0);
    xfer(0, 1'b0, 32'h04, 32'h0, 32'h0);
    // Status read with three wait states
    xfer(1, 1'b0, 32'h00, 32'h0, 32'h12345678);
    // Error transfers
    xfer(0, 1'b1, 32'h00, 32'hFFFFFFFF, 32'h0);
    xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 32'h0);
    xfer(0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);
    // Back-to-back
    c0 = cyc;
    xfer(0, 1'b1, 32'h08, 32'h1, 32'h0);
    xfer(0, 1'b1, 32'h0C, 32'h2, 32'h0);
    check("b2b_cycles", cyc - c0, 4);
    check("b2b_word2", ctrl[0][63:32], 32'h1);
    check("b2b_word3", ctrl[0][95:64], 32'h2);

    // Abort by dropping PSEL on the first access cycle
    xfer(2, 1'b1, 32'h10, 32'h5, 32'h0);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5A5A5;
    @(posedge PCLK); @(negedge PCLK);
    psel[2] = 1'b0; penable = 1'b1;
    check("abort_pready_access", pready[2], 0);
    @(posedge PCLK); @(negedge PCLK);
    penable = 1'b0;
    check("abort_pready_idle", pready[2], 0);
    check("abort_ctrl", ctrl[2], mdl_ctrl(2));
    $display("abort u2 ctrl_word4=%h", ctrl[2][127:96]);
    xfer(2, 1'b0, 32'h10, 32'h0, 32'h0);

    // Reset in the middle of an access phase
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5A5A5;
    @(posedge PCLK); @(negedge PCLK);
    penable = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    PRESET = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    mdl_clear();
    check_all_zero("midreset");
    $display("midreset u2 ctrl=%h", ctrl[2]);

    // Random transfers across all instances
    for (int n = 0; n < 60; n++) begin
      int i;
      logic [31:0] a;
      i = int'($urandom_range(0, 2));
      a = {25'd0, 3'($urandom_range(0, 7)), 2'($urandom)} + ($urandom_range(0, 5) == 0 ? 32'h20 : 32'h0);
      if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
      xfer(i, 1'($urandom), a, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge PCLK);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
